// File: rtl/spi_master_burst_if.sv
// Word-stream side of the burst SPI master: configuration, tx handshake, rx result and status.
// The master modport is the IO register block, the slave modport is the SPI engine.
interface spi_master_burst_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int CS_W   = 2
);
    logic [1:0]        i_cfg_mode;
    logic [DIV_W-1:0]  i_cfg_div;
    logic [CS_W-1:0]   i_cs_sel;
    logic [DATA_W-1:0] i_tx_data;
    logic              i_tx_last;
    logic              i_tx_valid;
    logic              o_tx_ready;
    logic              i_abort;
    logic [DATA_W-1:0] o_rx_data;
    logic              o_rx_valid;
    logic              o_busy;

    modport master (
        output i_cfg_mode, i_cfg_div, i_cs_sel, i_tx_data, i_tx_last, i_tx_valid, i_abort,
        input  o_tx_ready, o_rx_data, o_rx_valid, o_busy
    );

    modport slave (
        input  i_cfg_mode, i_cfg_div, i_cs_sel, i_tx_data, i_tx_last, i_tx_valid, i_abort,
        output o_tx_ready, o_rx_data, o_rx_valid, o_busy
    );
endinterface

// File: rtl/spi_master_burst.sv
// SPI master with runtime mode/divider, multi-word bursts under one chip select and abort.
// All pin and stream outputs come straight from the register set r.
module spi_master_burst #(
    parameter int DATA_W     = 8,
    parameter int NUM_CS     = 4,
    parameter int DIV_W      = 8,
    parameter int RESET_MODE = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    spi_master_burst_if.slave bus,
    output logic              o_spi_clk,
    output logic              o_spi_mosi,
    input  logic              i_spi_miso,
    output logic [NUM_CS-1:0] o_spi_cs_n
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int EW   = $clog2(2 * DATA_W) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);
    localparam logic [1:0]    RST_MODE  = 2'(RESET_MODE);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DESEL} state_t;

    typedef struct packed {
        state_t            state;
        logic [1:0]        mode;
        logic [DIV_W-1:0]  div;
        logic [DIV_W-1:0]  hcnt;
        logic [EW-1:0]     edges;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] rx_sr;
        logic [DATA_W-1:0] rx_data;
        logic              last;
        logic              rx_valid;
        logic              ready;
        logic              sclk;
        logic              mosi;
        logic [NUM_CS-1:0] cs_n;
    } regs_t;

    regs_t r, n;
    logic  tick, lead, sample, accept, load;
    logic [DATA_W-1:0] rx_shift;

    // Out-of-range selects leave every chip select deasserted.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(sel) == i) v[i] = 1'b0;
        end
        return v;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r       <= '0;
            r.state <= IDLE;
            r.mode  <= RST_MODE;
            r.sclk  <= RST_MODE[1];
            r.cs_n  <= '1;
        end else begin
            r <= n;
        end
    end

    always_comb begin
        n          = r;
        n.rx_valid = 1'b0;
        load       = 1'b0;
        tick       = (r.hcnt == r.div);
        lead       = ~r.edges[0];
        sample     = lead ^ r.mode[0];
        accept     = bus.i_tx_valid && r.ready;
        rx_shift   = {r.rx_sr[DATA_W-2:0], i_spi_miso};
        case (r.state)
            IDLE: begin
                if (accept) begin
                    n.mode = bus.i_cfg_mode;
                    n.div  = bus.i_cfg_div;
                    n.cs_n = cs_decode(bus.i_cs_sel);
                    n.sclk = bus.i_cfg_mode[1];
                    load   = 1'b1;
                end
            end
            SETUP, XFER: begin
                if (bus.i_abort) begin
                    n.state = DESEL;
                    n.sclk  = r.mode[1];
                    n.cs_n  = '1;
                    n.hcnt  = '0;
                end else if (!tick) begin
                    n.hcnt = r.hcnt + 1'b1;
                end else begin
                    // Every tick is one SCLK edge; SETUP's tick produces the first one.
                    n.hcnt  = '0;
                    n.sclk  = ~r.sclk;
                    n.edges = r.edges + 1'b1;
                    n.state = XFER;
                    if (sample) begin
                        n.rx_sr = rx_shift;
                    end else begin
                        n.data = r.data << 1;
                        n.mosi = r.mode[0] ? r.data[DATA_W-1] : r.data[DATA_W-2];
                    end
                    if (r.edges == LAST_EDGE) begin
                        n.rx_data  = sample ? rx_shift : r.rx_sr;
                        n.rx_valid = 1'b1;
                        n.state    = r.last ? DESEL : HOLD;
                        if (r.last) n.cs_n = '1;
                    end
                end
            end
            HOLD: begin
                if (bus.i_abort) begin
                    n.state = DESEL;
                    n.sclk  = r.mode[1];
                    n.cs_n  = '1;
                    n.hcnt  = '0;
                end else begin
                    load = accept;
                end
            end
            DESEL: begin
                if (tick) begin
                    n.state = IDLE;
                    n.hcnt  = '0;
                end else begin
                    n.hcnt = r.hcnt + 1'b1;
                end
            end
            default: n.state = IDLE;
        endcase
        // Word load shared by IDLE and HOLD; mode already reflects the burst settings.
        if (load) begin
            n.data  = bus.i_tx_data;
            n.last  = bus.i_tx_last;
            n.hcnt  = '0;
            n.edges = '0;
            n.state = SETUP;
            if (!n.mode[0]) n.mosi = bus.i_tx_data[DATA_W-1];
        end
        n.ready = (n.state == IDLE) || (n.state == HOLD);
    end

    assign bus.o_tx_ready = r.ready;
    assign bus.o_rx_data  = r.rx_data;
    assign bus.o_rx_valid = r.rx_valid;
    assign bus.o_busy     = (r.state != IDLE);
    assign o_spi_clk      = r.sclk;
    assign o_spi_mosi     = r.mosi;
    assign o_spi_cs_n     = r.cs_n;
endmodule

// File: tb/tb_spi_master_burst.sv
// Directed bench for spi_master_burst: vector table of single-word transfers plus burst,
// abort, reset and 16-bit long-divider sequences, with a behavioural SPI slave.
module tb_spi_master_burst;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_clk, spi_mosi, miso = 1'b0;
    logic [3:0] spi_cs_n;
    logic       sclk16, mosi16, miso16;
    logic [0:0] cs16;

    int tests = 0;
    int fails = 0;
    int rx_pulses = 0;

    spi_master_burst_if #(.DATA_W(8), .DIV_W(8), .CS_W(2)) ifc ();
    spi_master_burst_if #(.DATA_W(16), .DIV_W(8), .CS_W(1)) ifc16 ();

    spi_master_burst #(.DATA_W(8), .NUM_CS(4), .DIV_W(8), .RESET_MODE(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ifc), .o_spi_clk(spi_clk),
        .o_spi_mosi(spi_mosi), .i_spi_miso(miso), .o_spi_cs_n(spi_cs_n));

    spi_master_burst #(.DATA_W(16), .NUM_CS(1), .DIV_W(8), .RESET_MODE(0)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ifc16), .o_spi_clk(sclk16),
        .o_spi_mosi(mosi16), .i_spi_miso(miso16), .o_spi_cs_n(cs16));

    assign miso16 = mosi16;

    always #5 clk = ~clk;

    // Slave model: shifts slave_word out on the mode's shift edge, or loops MOSI back.
    logic [1:0] s_mode = 2'd0;
    logic [7:0] slave_word = 8'h00;
    logic [7:0] s_reg = 8'h00;
    bit         loop_en = 1'b1;
    logic       s_sel, s_prev_sel = 1'b0, s_prev_clk = 1'b0;

    always @(negedge clk) begin
        s_sel = (spi_cs_n != 4'hF);
        if (loop_en) begin
            miso = spi_mosi;
        end else if (s_sel && !s_prev_sel) begin
            s_reg = slave_word;
            if (!s_mode[0]) begin
                miso  = s_reg[7];
                s_reg = s_reg << 1;
            end
        end else if (s_sel && (spi_clk != s_prev_clk) && ((spi_clk != s_mode[1]) == s_mode[0])) begin
            miso  = s_reg[7];
            s_reg = s_reg << 1;
        end
        s_prev_sel = s_sel;
        s_prev_clk = spi_clk;
        if (ifc.o_rx_valid) rx_pulses++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One word through the 8-bit master; emode/h/ecs are the settings the word must run with.
    task automatic xfer(input logic [1:0] mode, input logic [7:0] div, input logic [1:0] cs,
                        input logic [7:0] tx, input logic last, input logic [1:0] emode,
                        input int h, input logic [3:0] ecs, input logic [7:0] erx, input string nm);
        int   cyc, edges, gap, k;
        bit   got, hp_ok, lead;
        logic prev;
        logic [7:0] mo;
        cyc = 0;
        while (!ifc.o_tx_ready && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s_ready", nm), 32'(ifc.o_tx_ready), 32'd1);
        s_mode = emode;
        ifc.i_cfg_mode = mode; ifc.i_cfg_div = div; ifc.i_cs_sel = cs;
        ifc.i_tx_data = tx; ifc.i_tx_last = last; ifc.i_tx_valid = 1'b1;
        @(negedge clk);
        ifc.i_tx_valid = 1'b0;
        check($sformatf("%s_cs", nm), 32'(spi_cs_n), 32'(ecs));
        prev = spi_clk; edges = 0; gap = 0; mo = '0; hp_ok = 1'b1; got = 1'b0; cyc = 0;
        while (!got && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            gap++;
            if (spi_clk != prev) begin
                edges++;
                if (gap != h) hp_ok = 1'b0;
                gap  = 0;
                lead = (spi_clk != emode[1]);
                if (lead ^ emode[0]) mo = {mo[6:0], spi_mosi};
                prev = spi_clk;
            end
            if (ifc.o_rx_valid) got = 1'b1;
        end
        check($sformatf("%s_rxvalid", nm), 32'(got), 32'd1);
        check($sformatf("%s_rx", nm), 32'(ifc.o_rx_data), 32'(erx));
        check($sformatf("%s_edges", nm), 32'(edges), 32'd16);
        check($sformatf("%s_mosi", nm), 32'(mo), 32'(tx));
        check($sformatf("%s_halfper", nm), 32'(hp_ok), 32'd1);
        check($sformatf("%s_sclk_idle", nm), 32'(spi_clk), 32'(emode[1]));
        check($sformatf("%s_cs_end", nm), 32'(spi_cs_n), last ? 32'hF : 32'(ecs));
        @(negedge clk);
        check($sformatf("%s_pulse", nm), 32'(ifc.o_rx_valid), 32'd0);
        if (last) begin
            k = 1;
            while (!ifc.o_tx_ready && k < 600) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("%s_desel", nm), 32'(k), 32'(h));
            check($sformatf("%s_idle_sclk", nm), 32'(spi_clk), 32'(emode[1]));
        end else begin
            check($sformatf("%s_hold_ready", nm), 32'(ifc.o_tx_ready), 32'd1);
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] div;
        logic [1:0] cs;
        logic [7:0] tx;
        bit         loop;
        logic [7:0] sword;
        logic [3:0] ecs;
        logic [7:0] erx;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   p0, bad, k, cyc, edges, gap, hp1;
        logic prev;
        logic [15:0] mo16;
        vecs[0] = '{2'd0, 8'd1, 2'd2, 8'hA5, 1'b1, 8'h00, 4'b1011, 8'hA5};
        vecs[1] = '{2'd0, 8'd0, 2'd0, 8'h5A, 1'b0, 8'h3C, 4'b1110, 8'h3C};
        vecs[2] = '{2'd1, 8'd0, 2'd0, 8'h5A, 1'b0, 8'h3C, 4'b1110, 8'h3C};
        vecs[3] = '{2'd2, 8'd0, 2'd0, 8'h5A, 1'b0, 8'h3C, 4'b1110, 8'h3C};
        vecs[4] = '{2'd3, 8'd0, 2'd0, 8'h5A, 1'b0, 8'h3C, 4'b1110, 8'h3C};
        vecs[5] = '{2'd3, 8'd2, 2'd3, 8'hC3, 1'b1, 8'h00, 4'b0111, 8'hC3};
        vecs[6] = '{2'd1, 8'd0, 2'd1, 8'h81, 1'b0, 8'hFF, 4'b1101, 8'hFF};

        ifc.i_cfg_mode = '0; ifc.i_cfg_div = '0; ifc.i_cs_sel = '0; ifc.i_tx_data = '0;
        ifc.i_tx_last = 1'b0; ifc.i_tx_valid = 1'b0; ifc.i_abort = 1'b0;
        ifc16.i_cfg_mode = '0; ifc16.i_cfg_div = '0; ifc16.i_cs_sel = '0; ifc16.i_tx_data = '0;
        ifc16.i_tx_last = 1'b0; ifc16.i_tx_valid = 1'b0; ifc16.i_abort = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ifc.o_tx_ready), 32'd0);
        check("rst_rxvalid", 32'(ifc.o_rx_valid), 32'd0);
        check("rst_rxdata", 32'(ifc.o_rx_data), 32'd0);
        check("rst_busy", 32'(ifc.o_busy), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_cs", 32'(spi_cs_n), 32'hF);
        check("rst_sclk", 32'(spi_clk), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(ifc.o_tx_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            loop_en = vecs[i].loop;
            slave_word = vecs[i].sword;
            xfer(vecs[i].mode, vecs[i].div, vecs[i].cs, vecs[i].tx, 1'b1, vecs[i].mode,
                 int'(vecs[i].div) + 1, vecs[i].ecs, vecs[i].erx, $sformatf("vec%0d", i));
        end

        // Burst of three words with a long gap and ignored cfg changes during HOLD.
        loop_en = 1'b1;
        p0 = rx_pulses;
        xfer(2'd0, 8'd0, 2'd1, 8'h01, 1'b0, 2'd0, 1, 4'b1101, 8'h01, "burst1");
        ifc.i_cfg_mode = 2'd3; ifc.i_cfg_div = 8'd5; ifc.i_cs_sel = 2'd0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (spi_cs_n != 4'b1101 || !ifc.o_tx_ready || !ifc.o_busy) bad++;
        end
        check("burst_hold", 32'(bad), 32'd0);
        xfer(2'd3, 8'd5, 2'd0, 8'h02, 1'b0, 2'd0, 1, 4'b1101, 8'h02, "burst2");
        xfer(2'd2, 8'd7, 2'd3, 8'h03, 1'b1, 2'd0, 1, 4'b1101, 8'h03, "burst3");
        check("burst_pulses", 32'(rx_pulses - p0), 32'd3);

        // Abort in the middle of the second word of a burst.
        xfer(2'd0, 8'd1, 2'd0, 8'h11, 1'b0, 2'd0, 2, 4'b1110, 8'h11, "abort1");
        p0 = rx_pulses;
        ifc.i_tx_data = 8'h22; ifc.i_tx_last = 1'b1; ifc.i_tx_valid = 1'b1;
        @(negedge clk);
        ifc.i_tx_valid = 1'b0;
        repeat (6) @(negedge clk);
        ifc.i_abort = 1'b1;
        @(negedge clk);
        ifc.i_abort = 1'b0;
        check("abort_cs", 32'(spi_cs_n), 32'hF);
        check("abort_sclk", 32'(spi_clk), 32'd0);
        check("abort_busy", 32'(ifc.o_busy), 32'd1);
        k = 0;
        while (!ifc.o_tx_ready && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("abort_ready_after", 32'(k), 32'd2);
        repeat (4) @(negedge clk);
        check("abort_no_rx", 32'(rx_pulses - p0), 32'd0);

        // Reset during XFER in mode 2, then a normal transfer.
        p0 = rx_pulses;
        ifc.i_cfg_mode = 2'd2; ifc.i_cfg_div = 8'd3; ifc.i_cs_sel = 2'd3;
        ifc.i_tx_data = 8'h77; ifc.i_tx_last = 1'b1; ifc.i_tx_valid = 1'b1;
        @(negedge clk);
        ifc.i_tx_valid = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_cs", 32'(spi_cs_n), 32'hF);
        check("mid_rst_sclk", 32'(spi_clk), 32'd0);
        check("mid_rst_busy", 32'(ifc.o_busy), 32'd0);
        check("mid_rst_ready", 32'(ifc.o_tx_ready), 32'd0);
        check("mid_rst_rxdata", 32'(ifc.o_rx_data), 32'd0);
        check("mid_rst_mosi", 32'(spi_mosi), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_rel_ready", 32'(ifc.o_tx_ready), 32'd1);
        check("mid_rst_no_rx", 32'(rx_pulses - p0), 32'd0);
        xfer(2'd1, 8'd0, 2'd1, 8'h96, 1'b1, 2'd1, 1, 4'b1101, 8'h96, "post_rst");

        // 16-bit build with the largest divider: 256-clock half periods, 32 edges.
        check("w16_ready", 32'(ifc16.o_tx_ready), 32'd1);
        ifc16.i_cfg_mode = 2'd0; ifc16.i_cfg_div = 8'hFF; ifc16.i_cs_sel = 1'b0;
        ifc16.i_tx_data = 16'hBEEF; ifc16.i_tx_last = 1'b1; ifc16.i_tx_valid = 1'b1;
        @(negedge clk);
        ifc16.i_tx_valid = 1'b0;
        check("w16_cs", 32'(cs16), 32'd0);
        prev = sclk16; edges = 0; gap = 0; hp1 = 0; mo16 = '0; cyc = 0;
        while (!ifc16.o_rx_valid && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            gap++;
            if (sclk16 != prev) begin
                edges++;
                if (edges == 2) hp1 = gap;
                if (sclk16) mo16 = {mo16[14:0], mosi16};
                gap  = 0;
                prev = sclk16;
            end
        end
        check("w16_rxvalid", 32'(ifc16.o_rx_valid), 32'd1);
        check("w16_rx", 32'(ifc16.o_rx_data), 32'hBEEF);
        check("w16_edges", 32'(edges), 32'd32);
        check("w16_halfper", 32'(hp1), 32'd256);
        check("w16_mosi", 32'(mo16), 32'hBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
